// File: rtl/snn_axi4l_regfile.sv
// -----------------------------------------------------------------------------
// snn_axi4l_regfile
//
// AXI4-Lite register file that feeds an image to a spiking neural network and
// collects the inferred digit.
//
// Register map (byte addresses):
//   0x000 .. 4*(IMG_WORDS-1) : image words, R/W, PPW pixels packed per word
//   0x800 CTRL   : bit0 START (write-1 pulse, reads 0), bit1 IE (R/W)
//   0x804 STATUS : bit0 BUSY (RO), bit1 DONE (write-1-to-clear)
//   0x808 RESULT : [M-1:0] last captured digit (RO)
//   0x80C ID     : {IMAGE_SIZE[15:0], PIXEL_BITS[7:0], M[7:0]} (RO)
//
// Ports:
//   ACLK, ARESETN           : clock, synchronous active-low reset
//   AW*/W*/B*/AR*/R*        : AXI4-Lite slave (AWPROT/ARPROT ignored)
//   IMAGE[IMAGE_SIZE]       : pixel array, straight from the storage words
//   NEW_IMAGE               : one-cycle start pulse to the SNN
//   INFER_DONE              : one-cycle completion pulse from the SNN
//   INFERED_DIGIT[M-1:0]    : result, valid with INFER_DONE
//   IRQ                     : level interrupt DONE & IE, registered
//                             (port exists only with SNN_AXI4L_IRQ_EN)
//
// Build option: define SNN_AXI4L_IRQ_EN to build CTRL.IE and the IRQ output.
// -----------------------------------------------------------------------------
module snn_axi4l_regfile #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int IMAGE_SIZE     = 256,
    parameter int PIXEL_BITS     = 8,
    parameter int M              = 8
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    input  logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]                  AWPROT,
    input  logic                        AWVALID,
    output logic                        AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                        WVALID,
    output logic                        WREADY,
    output logic [1:0]                  BRESP,
    output logic                        BVALID,
    input  logic                        BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]                  ARPROT,
    input  logic                        ARVALID,
    output logic                        ARREADY,
    output logic [AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                  RRESP,
    output logic                        RVALID,
    input  logic                        RREADY,
    output logic [PIXEL_BITS-1:0]       IMAGE [IMAGE_SIZE],
    output logic                        NEW_IMAGE,
    input  logic                        INFER_DONE,
    input  logic [M-1:0]                INFERED_DIGIT
`ifdef SNN_AXI4L_IRQ_EN
    ,
    output logic                        IRQ
`endif
);

    localparam int PPW       = 32 / PIXEL_BITS;
    localparam int IMG_WORDS = IMAGE_SIZE / PPW;
    localparam int IDX_W     = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1;
    localparam int NSTRB     = AXI_DATA_WIDTH / 8;

    localparam logic [AXI_ADDR_WIDTH-1:0] IMG_END     = AXI_ADDR_WIDTH'(4 * IMG_WORDS);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_CTRL   = AXI_ADDR_WIDTH'(12'h800);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STATUS = AXI_ADDR_WIDTH'(12'h804);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_RESULT = AXI_ADDR_WIDTH'(12'h808);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_ID     = AXI_ADDR_WIDTH'(12'h80C);
    localparam logic [AXI_DATA_WIDTH-1:0] ID_VALUE    =
        AXI_DATA_WIDTH'({16'(IMAGE_SIZE), 8'(PIXEL_BITS), 8'(M)});

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Storage and control state
    logic [AXI_DATA_WIDTH-1:0] mem [IMG_WORDS];
    logic                      busy;
    logic                      done;
    logic [M-1:0]              result;
`ifdef SNN_AXI4L_IRQ_EN
    logic                      ie;
    logic                      irq_q;
`endif

    // Write-channel holders
    logic                      aw_full;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic                      w_full;
    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [NSTRB-1:0]          w_strb;

    // Registered outputs
    logic                      out_of_reset;
    logic                      bvalid_q;
    logic [1:0]                bresp_q;
    logic                      rvalid_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                rresp_q;
    logic                      new_image_q;

    logic unused_prot;
    assign unused_prot = ^{AWPROT, ARPROT};

    // Handshakes: a transfer happens on any ACLK edge where VALID and READY are
    // both high. VALID never depends on READY. Each write channel has a
    // one-entry holder; READY is offered only while that holder is empty and no
    // B response is outstanding. Once both holders are full, the write commits
    // on the next edge, which also raises BVALID (held until BREADY). ARREADY is
    // !RVALID; R data is registered at the AR handshake and held until RREADY.
    // out_of_reset keeps all READYs low while ARESETN is asserted.
    assign AWREADY = out_of_reset && !aw_full && !bvalid_q;
    assign WREADY  = out_of_reset && !w_full && !bvalid_q;
    assign ARREADY = out_of_reset && !rvalid_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign NEW_IMAGE = new_image_q;
`ifdef SNN_AXI4L_IRQ_EN
    assign IRQ = irq_q;
`endif

    // Write decode of the held address
    logic commit;
    logic wr_img, wr_ctrl, wr_status, wr_err;
    logic start_go, done_set, done_clr;

    always_comb begin
        wr_img    = 1'b0;
        wr_ctrl   = 1'b0;
        wr_status = 1'b0;
        wr_err    = 1'b1;
        if (aw_addr[1:0] == 2'b00) begin
            if (aw_addr < IMG_END) begin
                // Image is frozen while the SNN is consuming it
                wr_img = !busy;
                wr_err = busy;
            end else if (aw_addr == ADDR_CTRL) begin
                wr_ctrl = 1'b1;
                wr_err  = 1'b0;
            end else if (aw_addr == ADDR_STATUS) begin
                wr_status = 1'b1;
                wr_err    = 1'b0;
            end
        end
    end

    assign commit   = aw_full && w_full;
    assign start_go = commit && wr_ctrl && w_strb[0] && w_data[0] && !busy;
    assign done_clr = commit && wr_status && w_strb[0] && w_data[1];
    assign done_set = INFER_DONE && busy;

    // Read decode straight from ARADDR; sampled only at the AR handshake, so a
    // same-cycle write commit is seen by the next read, not this one.
    logic [AXI_DATA_WIDTH-1:0] rd_data;
    logic                      rd_err;

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        if (ARADDR[1:0] != 2'b00) begin
            rd_err = 1'b1;
        end else if (ARADDR < IMG_END) begin
            rd_data = mem[ARADDR[IDX_W+1:2]];
        end else if (ARADDR == ADDR_CTRL) begin
`ifdef SNN_AXI4L_IRQ_EN
            rd_data[1] = ie;
`endif
        end else if (ARADDR == ADDR_STATUS) begin
            rd_data[1:0] = {done, busy};
        end else if (ARADDR == ADDR_RESULT) begin
            rd_data = AXI_DATA_WIDTH'(result);
        end else if (ARADDR == ADDR_ID) begin
            rd_data = ID_VALUE;
        end else begin
            rd_err = 1'b1;
        end
    end

    // Image storage with per-lane write enables
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            for (int i = 0; i < IMG_WORDS; i++) mem[i] <= '0;
        end else if (commit && wr_img) begin
            for (int b = 0; b < NSTRB; b++) begin
                if (w_strb[b]) mem[aw_addr[IDX_W+1:2]][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
    end

    for (genvar gi = 0; gi < IMAGE_SIZE; gi++) begin : g_pix
        assign IMAGE[gi] = mem[gi / PPW][(gi % PPW) * PIXEL_BITS +: PIXEL_BITS];
    end

    // AXI channel state
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            out_of_reset <= 1'b0;
            aw_full      <= 1'b0;
            aw_addr      <= '0;
            w_full       <= 1'b0;
            w_data       <= '0;
            w_strb       <= '0;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
        end else begin
            out_of_reset <= 1'b1;
            if (AWVALID && AWREADY) begin
                aw_full <= 1'b1;
                aw_addr <= AWADDR;
            end
            if (WVALID && WREADY) begin
                w_full <= 1'b1;
                w_data <= WDATA;
                w_strb <= WSTRB;
            end
            if (commit) begin
                aw_full  <= 1'b0;
                w_full   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && BREADY) begin
                bvalid_q <= 1'b0;
            end
            if (ARVALID && ARREADY) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
                rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (rvalid_q && RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Inference control. start_go needs !busy and done_set needs busy, so they
    // never coincide; done_set outranks a same-cycle DONE clear.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            new_image_q <= 1'b0;
        end else begin
            new_image_q <= start_go;
            if (start_go) begin
                busy <= 1'b1;
                done <= 1'b0;
            end else if (done_set) begin
                busy   <= 1'b0;
                done   <= 1'b1;
                result <= INFERED_DIGIT;
            end else if (done_clr) begin
                done <= 1'b0;
            end
        end
    end

`ifdef SNN_AXI4L_IRQ_EN
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            ie    <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (commit && wr_ctrl && w_strb[0]) ie <= w_data[1];
            irq_q <= done & ie;
        end
    end
`endif

endmodule
